i2c_target: RTL

//  I2C responder (target) that answers transfers from our i2c_controller or any

---
 rtl/i2c_pkg.sv | 40 ++++
 rtl/i2c_line_filter.sv | 61 ++++++
 rtl/i2c_target.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus-level constants and
// START/STOP detection helpers.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_e;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // SCL counts as high if it was high before this sample, so an SCL edge
  // coinciding with the SDA edge still yields START/STOP.
  function automatic logic scl_was_high(input logic scl_lvl, input logic scl_rose,
                                        input logic scl_fell);
    return (scl_lvl & ~scl_rose) | scl_fell;
  endfunction

  function automatic logic is_start(input logic scl_lvl, input logic scl_rose,
                                    input logic scl_fell, input logic sda_fell);
    return sda_fell & scl_was_high(scl_lvl, scl_rose, scl_fell);
  endfunction

  function automatic logic is_stop(input logic scl_lvl, input logic scl_rose,
                                   input logic scl_fell, input logic sda_rose);
    return sda_rose & scl_was_high(scl_lvl, scl_rose, scl_fell);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus deglitch filter for one open-drain bus line.
// The filtered level only follows the input after FILTER_LEN identical
// consecutive synchronised samples; rise/fall pulse with the level change.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Count consecutive samples that disagree with the filtered level.
  always_comb begin
    sync_d  = {sync_q[0], din};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Idle bus is high, so all line state resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target bridging 7-bit-address transfers onto a byte-wide register bus.
// Write: START, addr+W, pointer, data...; read: repeated START, addr+R, data...
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (scl_in),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sda_in),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start_det = is_start(scl, scl_rise, scl_fall, sda_fall);
  assign stop_det  = is_stop(scl, scl_rise, scl_fall, sda_rise);

  i2c_tgt_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       load_q, load_d;
  logic [7:0] byte_in;

  assign byte_in = {shift_q[6:0], sda};

  // Next-state and datapath: protocol FSM, then START/STOP/en overrides.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    load_d      = load_q;

    case (state_q)
      ST_IDLE: sda_oe_d = 1'b0;

      ST_ADDR: begin
        if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (byte_in[7:1] == TARGET_ADDR && byte_in[7:1] != 7'd0) begin
              busy_d = 1'b1;
              rw_d   = byte_in[0];
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          sda_oe_d = ~ACK_BIT;
          state_d  = ST_ADDR_ACK;
        end
      end

      ST_ADDR_ACK: begin
        if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          if (rw_q == RW_READ) begin
            reg_re_d = 1'b1;
            load_d   = 1'b0;
            state_d  = ST_RDATA;
          end else begin
            state_d = ST_REG;
          end
        end
      end

      ST_REG: begin
        if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) reg_addr_d = byte_in;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          sda_oe_d = ~ACK_BIT;
          state_d  = ST_REG_ACK;
        end
      end

      ST_REG_ACK: begin
        if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = ST_WDATA;
        end
      end

      ST_WDATA: begin
        if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            reg_wdata_d = byte_in;
            reg_we_d    = 1'b1;
          end
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          sda_oe_d = ~ACK_BIT;
          state_d  = ST_WDATA_ACK;
        end
      end

      ST_WDATA_ACK: begin
        if (scl_fall) begin
          sda_oe_d   = 1'b0;
          bit_cnt_d  = 4'd0;
          reg_addr_d = reg_addr_q + 8'd1;
          state_d    = ST_WDATA;
        end
      end

      // load_q marks a byte after master ACK whose read strobe waits for SCL fall;
      // the strobe from ADDR_ACK is issued on the entering fall itself.
      ST_RDATA: begin
        if (reg_re_q) begin
          tx_d     = reg_rdata;
          sda_oe_d = ~reg_rdata[7];
        end else if (scl_fall) begin
          if (load_q) begin
            reg_re_d = 1'b1;
            load_d   = 1'b0;
          end else if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = ST_RDATA_ACK;
          end else begin
            tx_d     = {tx_q[6:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end else if (scl_rise && !load_q) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      ST_RDATA_ACK: begin
        sda_oe_d = 1'b0;
        if (scl_rise) begin
          if (sda == ACK_BIT) begin
            reg_addr_d = reg_addr_q + 8'd1;
            bit_cnt_d  = 4'd0;
            load_d     = 1'b1;
            state_d    = ST_RDATA;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
      end

      ST_WAIT_STOP: sda_oe_d = 1'b0;

      default: state_d = ST_IDLE;
    endcase

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      reg_we_d  = 1'b0;
      reg_re_d  = 1'b0;
      load_d    = 1'b0;
    end
    if (stop_det || !en) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      reg_we_d = 1'b0;
      reg_re_d = 1'b0;
      load_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= RW_WRITE;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      load_q      <= load_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule
